// File: rtl/led_seq_pkg.sv
// Shared types and pattern tables for the LED sequencer.
// Patterns are packed four bits per step, step 0 in the low nibble.
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_CHASE  = 2'd2,
        MODE_BOUNCE = 2'd3
    } mode_t;

    typedef logic [2:0] step_t;

    localparam step_t LEN_BLINK  = 3'd2;
    localparam step_t LEN_CHASE  = 3'd4;
    localparam step_t LEN_BOUNCE = 3'd6;

    localparam logic [7:0]  BLINK_ROM  = {4'b0000, 4'b1111};
    localparam logic [15:0] CHASE_ROM  = {4'b1000, 4'b0100, 4'b0010, 4'b0001};
    localparam logic [23:0] BOUNCE_ROM = {4'b0010, 4'b0100, 4'b1000,
                                          4'b0100, 4'b0010, 4'b0001};

    function automatic step_t pattern_len(mode_t m);
        case (m)
            MODE_BLINK:  return LEN_BLINK;
            MODE_CHASE:  return LEN_CHASE;
            MODE_BOUNCE: return LEN_BOUNCE;
            default:     return 3'd1;
        endcase
    endfunction

    function automatic logic [3:0] pattern_led(mode_t m, step_t s);
        case (m)
            MODE_BLINK:  return BLINK_ROM[{s[0], 2'b00} +: 4];
            MODE_CHASE:  return CHASE_ROM[{s[1:0], 2'b00} +: 4];
            MODE_BOUNCE: return (s < LEN_BOUNCE) ? BOUNCE_ROM[{s, 2'b00} +: 4] : 4'b0000;
            default:     return 4'b0000;
        endcase
    endfunction

    function automatic step_t next_step(mode_t m, step_t s);
        return (s == pattern_len(m) - 3'd1) ? 3'd0 : s + 3'd1;
    endfunction

endpackage

// File: rtl/led_timebase.sv
// Free-running prescaler: counts 0..PERIOD-1 while enabled and flags the
// terminal count combinationally so the caller can register it with the pattern step.
module led_timebase #(
    parameter int WIDTH  = 26,
    parameter int PERIOD = 3000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] cnt,
    output logic             tick_d
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(PERIOD - 1);

    assign tick_d = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick_d ? '0 : cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/led_sequencer.sv
// LED pattern controller: mode FSM stepped by the timebase, with mode changes
// deferred to tick boundaries unless starting from OFF or switching to OFF.
//
//   state        | meaning
//   MODE_OFF     | LEDs and heartbeat dark, prescaler held at 0
//   MODE_BLINK   | all four LEDs on/off, 2 steps
//   MODE_CHASE   | single LED walks D1->D4, 4 steps
//   MODE_BOUNCE  | single LED walks D1->D4->D1, 6 steps
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int WIDTH  = 26,
    parameter int PERIOD = 3000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] mode,
    input  logic       mode_valid,
    output logic       mode_ready,
    input  logic       pause,
    output logic       tick,
    output logic [3:0] led,
    output logic       d5
);

    mode_t            mode_q;
    mode_t            pend_mode;
    logic             pend_valid;
    step_t            step;
    mode_t            req_mode;
    logic             run;
    logic             req_now;
    logic             req_defer;
    logic             tick_d;
    logic [WIDTH-1:0] cnt_unused;

    // OFF requests and requests made from OFF apply immediately; anything
    // else waits for the next tick so a period is never cut short.
    always_comb begin
        req_mode  = mode_t'(mode);
        run       = (mode_q != MODE_OFF) && !pause;
        req_now   = mode_valid && ((mode_q == MODE_OFF) || (req_mode == MODE_OFF));
        req_defer = mode_valid && !req_now && !pend_valid;
    end

    led_timebase #(
        .WIDTH (WIDTH),
        .PERIOD(PERIOD)
    ) u_timebase (
        .clk   (clk),
        .reset (reset),
        .clr   (req_now),
        .en    (run),
        .cnt   (cnt_unused),
        .tick_d(tick_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q     <= MODE_OFF;
            pend_mode  <= MODE_OFF;
            pend_valid <= 1'b0;
            step       <= '0;
            led        <= '0;
            d5         <= 1'b0;
            tick       <= 1'b0;
            mode_ready <= 1'b1;
        end else if (req_now) begin
            mode_q     <= req_mode;
            pend_valid <= 1'b0;
            mode_ready <= 1'b1;
            step       <= '0;
            led        <= pattern_led(req_mode, 3'd0);
            d5         <= (req_mode != MODE_OFF);
            tick       <= 1'b0;
        end else begin
            tick <= tick_d;
            if (tick_d) begin
                d5 <= !d5;
                if (pend_valid) begin
                    mode_q     <= pend_mode;
                    step       <= '0;
                    led        <= pattern_led(pend_mode, 3'd0);
                    pend_valid <= 1'b0;
                    mode_ready <= 1'b1;
                end else begin
                    step <= next_step(mode_q, step);
                    led  <= pattern_led(mode_q, next_step(mode_q, step));
                end
            end
            // req_defer excludes an existing pending request, so this never
            // collides with the pending hand-over above.
            if (req_defer) begin
                pend_valid <= 1'b1;
                pend_mode  <= req_mode;
                mode_ready <= 1'b0;
            end
        end
    end

endmodule
